// File: rtl/io_pkg.sv
// Shared IO-bus constants: responder select bit, store-mask encodings, register map.
// No logic; latency n/a.
// Backpressure n/a.
package io_pkg;

    localparam int IO_SEL_BIT = 22;

    localparam logic [4:0] WMASK_IDLE = 5'b00000;
    localparam logic [4:0] WMASK_BYTE = 5'b00111;
    localparam logic [4:0] WMASK_HALF = 5'b01111;
    localparam logic [4:0] WMASK_WORD = 5'b11111;

    // Word-address bits that pick an IO register
    localparam int IO_LED_BIT       = 2;
    localparam int IO_UART_DATA_BIT = 3;
    localparam int IO_UART_STAT_BIT = 4;

    // Bit positions inside the UART status word
    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] uart_status(input logic ovf, input logic full, input logic busy);
        logic [31:0] w;
        w            = '0;
        w[STAT_OVF]  = ovf;
        w[STAT_FULL] = full;
        w[STAT_BUSY] = busy;
        return w;
    endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// CPU IO-bus port bundle: address, store data/mask from the CPU, registered read data back.
// No logic; latency n/a.
// Backpressure: none, the bus has no stall.
interface io_uart_tx_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_wmask;
    logic [31:0] io_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wmask,
        input  io_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wmask,
        output io_rdata
    );
endinterface

// File: rtl/io_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible on dout the cycle after it is sampled.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // When full, the slot being read out this cycle is the one overwritten
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: data register feeds a byte FIFO, status register reports busy/full/overflow.
// Latency: line falls one cycle after the store into an idle transmitter; reads return one cycle after address.
// Backpressure: none on the bus; a store into a full FIFO is dropped and sets a sticky overflow flag.
module io_uart_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_BIT     = IO_UART_DATA_BIT,
    parameter int STATUS_BIT   = IO_UART_STAT_BIT
) (
    input  logic            clk,
    input  logic            RESET,
    io_uart_tx_if.slave     bus,
    output logic            uart_tx,
    output logic            busy
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t      state;
    tx_state_t      state_nxt;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           baud_end;
    logic           overflow;

    logic           sel;
    logic           data_wr;
    logic           stat_wr;
    logic           ovf_set;
    logic           ovf_clr;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;

    logic           unused_bits;

    // ---------------- bus decode ----------------
    assign sel     = bus.mem_addr[IO_SEL_BIT];
    assign data_wr = sel & bus.mem_wmask[0] & bus.mem_addr[DATA_BIT];
    assign stat_wr = sel & bus.mem_wmask[0] & bus.mem_addr[STATUS_BIT];

    // A push into a full FIFO only survives if the serializer frees a slot this cycle
    assign ovf_set = data_wr & fifo_full & ~fifo_pop;
    assign ovf_clr = stat_wr & bus.mem_wdata[STAT_OVF];

    assign unused_bits = ^{bus.mem_addr, bus.mem_wdata, bus.mem_wmask};

    io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .RESET (RESET),
        .push  (data_wr),
        .pop   (fifo_pop),
        .din   (bus.mem_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign busy = (fifo_count != '0) | (state != TX_IDLE);

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            bus.io_rdata <= '0;
        end else if (sel & bus.mem_addr[STATUS_BIT]) begin
            bus.io_rdata <= uart_status(overflow, fifo_full, busy);
        end else begin
            bus.io_rdata <= '0;
        end
    end

    // ---------------- serializer ----------------
    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state <= TX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        uart_tx   = 1'b1;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = TX_START;
                end
            end
            TX_START: begin
                uart_tx = 1'b0;
                if (baud_end) state_nxt = TX_DATA;
            end
            TX_DATA: begin
                uart_tx = shift[0];
                if (baud_end && bit_idx == 3'd7) state_nxt = TX_STOP;
            end
            TX_STOP: begin
                // Chain straight into the next start bit so queued frames are contiguous
                if (baud_end) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = TX_START;
                    end else begin
                        state_nxt = TX_IDLE;
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else if (fifo_pop) begin
            shift    <= fifo_dout;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else if (state != TX_IDLE) begin
            baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
            if (state == TX_DATA && baud_end) begin
                shift   <= {1'b0, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: vector tables for reads and mask variants,
// hand sequences for exact waveform, back-to-back, overflow and mid-frame reset.
module tb_io_uart_tx;
    import io_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam logic [31:0] A_DATA = 32'h0040_0008;
    localparam logic [31:0] A_STAT = 32'h0040_0010;

    logic clk   = 1'b0;
    logic RESET = 1'b1;
    logic uart_tx;
    logic busy;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [7:0] sb [$];

    io_uart_tx_if bus();

    io_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_BIT     (3),
        .STATUS_BIT   (4)
    ) dut (
        .clk     (clk),
        .RESET   (RESET),
        .bus     (bus),
        .uart_tx (uart_tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level at cycle j of a frame carrying byte b
    function automatic logic exp_line(input logic [7:0] b, input int j);
        if (j < CPB) return 1'b0;
        if (j < 9 * CPB) return b[(j - CPB) / CPB];
        return 1'b1;
    endfunction

    // All bus tasks start and end 1 time unit after a rising edge
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] mask);
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        bus.mem_wmask = mask;
        @(posedge clk); #1;
        bus.mem_wmask = WMASK_IDLE;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus.mem_addr  = addr;
        bus.mem_wmask = WMASK_IDLE;
        @(posedge clk); #1;
        check(name, bus.io_rdata, exp);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // k counts falling edges after the first write edge; frames start at k=1
    task automatic check_wave(input logic [7:0] b0, input logic [7:0] b1, input int nfr, input int k0);
        for (int k = k0; k <= nfr * FRAME + 1; k++) begin
            @(negedge clk);
            if (k == nfr * FRAME + 1) begin
                check("busy_fall", busy, 0);
                check("line_idle", uart_tx, 1);
            end else begin
                check("busy_hi", busy, 1);
                if (k == 0) check("line_pre", uart_tx, 1);
                else check("line", uart_tx, exp_line(((k - 1) / FRAME == 0) ? b0 : b1, (k - 1) % FRAME));
            end
        end
        @(posedge clk); #1;
    endtask

    // Serial monitor: decodes frames mid-bit and pops the scoreboard
    initial begin
        int         ph;
        logic       in_frame;
        logic [7:0] b;
        logic [7:0] e;
        in_frame = 1'b0;
        ph       = 0;
        b        = '0;
        forever begin
            @(negedge clk);
            if (RESET) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (uart_tx === 1'b0) begin
                    in_frame = 1'b1;
                    ph       = 0;
                    b        = '0;
                end
            end else begin
                ph++;
                if (ph >= CPB && ph < 9 * CPB && (ph % CPB) == CPB / 2)
                    b[ph / CPB - 1] = uart_tx;
                if (ph == 9 * CPB + CPB / 2) begin
                    check("mon_stop", uart_tx, 1);
                    if (sb.size() == 0) begin
                        check("mon_unexpected_frame", b, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("mon_byte", b, e);
                    end
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [4:0]  wmask;
        logic [31:0] wdata;
        logic        sends;
        logic [7:0]  exp_byte;
    } tx_vec_t;

    initial begin
        rd_vec_t    rd_tab [5];
        tx_vec_t    tx_tab [6];
        logic [7:0] ovf_bytes [7];
        int         e0;

        rd_tab[0] = '{A_STAT,         32'h0};
        rd_tab[1] = '{A_DATA,         32'h0};
        rd_tab[2] = '{32'h0000_0010,  32'h0};
        rd_tab[3] = '{32'h0040_0018,  32'h0};
        rd_tab[4] = '{32'h0000_0018,  32'h0};

        tx_tab[0] = '{WMASK_BYTE, 32'hDEAD_BE41, 1'b1, 8'h41};
        tx_tab[1] = '{WMASK_HALF, 32'hDEAD_BE41, 1'b1, 8'h41};
        tx_tab[2] = '{WMASK_WORD, 32'hDEAD_BE41, 1'b1, 8'h41};
        tx_tab[3] = '{WMASK_BYTE, 32'h0000_00FF, 1'b1, 8'hFF};
        tx_tab[4] = '{WMASK_WORD, 32'h1234_5600, 1'b1, 8'h00};
        tx_tab[5] = '{WMASK_IDLE, 32'h0000_0077, 1'b0, 8'h00};

        ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

        // ---- reset state ----
        bus.mem_addr  = A_STAT;
        bus.mem_wdata = '0;
        bus.mem_wmask = WMASK_IDLE;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rdata", bus.io_rdata, 0);
        RESET = 1'b0;
        @(posedge clk); #1;

        // ---- idle reads ----
        for (int i = 0; i < 5; i++) bus_read(rd_tab[i].addr, rd_tab[i].exp, "idle_read");

        // ---- single byte, exact waveform ----
        sb.push_back(8'h55);
        bus_write(A_DATA, 32'h55, WMASK_BYTE);
        check_wave(8'h55, 8'h55, 1, 0);

        // ---- back-to-back frames ----
        sb.push_back(8'hA5);
        sb.push_back(8'h3C);
        bus_write(A_DATA, 32'hA5, WMASK_BYTE);
        bus_write(A_DATA, 32'h3C, WMASK_BYTE);
        check_wave(8'hA5, 8'h3C, 2, 1);
        check("b2b_sb_drain", sb.size(), 0);

        // ---- mask variants ----
        for (int i = 0; i < 6; i++) begin
            if (tx_tab[i].sends) sb.push_back(tx_tab[i].exp_byte);
            bus_write(A_DATA, tx_tab[i].wdata, tx_tab[i].wmask);
            wait_idle(FRAME + 20);
            check("mask_sb_drain", sb.size(), 0);
        end

        // ---- overflow ----
        e0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) sb.push_back(ovf_bytes[i]);
            bus_write(A_DATA, {24'h0, ovf_bytes[i]}, WMASK_BYTE);
            if (i == 0) e0 = cyc;
        end
        bus_read(A_STAT, 32'h7, "ovf_status_set");
        bus_write(A_STAT, 32'h4, WMASK_WORD);
        bus_read(A_STAT, 32'h3, "ovf_status_clr");
        // Data and status in one store while full: byte dropped, set beats clear
        bus_write(A_DATA | A_STAT, 32'h4, WMASK_WORD);
        bus_read(A_STAT, 32'h7, "ovf_set_wins");
        bus_write(A_STAT, 32'h4, WMASK_WORD);
        bus_read(A_STAT, 32'h3, "ovf_status_clr2");
        // Strobe exactly on the edge where the first frame ends and a slot is popped
        while (cyc < e0 + 40) begin
            @(posedge clk); #1;
        end
        sb.push_back(ovf_bytes[6]);
        bus_write(A_DATA, {24'h0, ovf_bytes[6]}, WMASK_BYTE);
        bus_read(A_STAT, 32'h3, "push_pop_full");
        wait_idle(7 * FRAME);
        check("ovf_sb_drain", sb.size(), 0);
        bus_read(A_STAT, 32'h0, "ovf_final_status");

        // ---- reset mid-frame ----
        bus_write(A_DATA, 32'h81, WMASK_BYTE);
        e0 = cyc;
        bus_write(A_DATA, 32'h42, WMASK_BYTE);
        bus_write(A_DATA, 32'h24, WMASK_BYTE);
        while (cyc < e0 + 18) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", busy, 1);
        RESET = 1'b1;
        #1;
        check("midrst_line", uart_tx, 1);
        check("midrst_busy", busy, 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        RESET = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("postrst_line", uart_tx, 1);
            check("postrst_busy", busy, 0);
        end
        @(posedge clk); #1;
        bus_read(A_STAT, 32'h0, "postrst_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
